pipelined_control_unit: RTL and testbench
=========================================

// Module: pipelined_control_unit
// PURPOSE
//  Parametrised 5-stage RISC-V control unit: decodes opcode in ID, carries control bundle through
//  ID/EX, EX/MEM, MEM/WB registers. Detects load-use hazards (stall + bubble) and applies branch/jump
//  flush. Sits beside pipelined datapath; replaces single-cycle decoder.
// PARAMETERS
//  ALU_OP_W    2  ALU_OP width; must be >=3 when EXT_OPS=1
//  REG_ADDR_W  5  register-index width
//  EXT_OPS     0  1 = also decode LUI(0110111), AUIPC(0010111), JALR(1100111)
// PORTS
//  clk            in   1           clock, rising edge
//  arst_n         in   1           async reset, active low
//  id_opcode      in   7           opcode of instruction in ID
//  id_rs1         in   REG_ADDR_W  rs1 field in ID
//  id_rs2         in   REG_ADDR_W  rs2 field in ID
//  id_rd          in   REG_ADDR_W  rd field in ID
//  flush          in   1           branch/jump taken (resolved in MEM): squash ID/EX, EX/MEM
//  hazard_stall   out  1           load-use stall; datapath holds PC and IF/ID
//  id_illegal     out  1           ID opcode not decodable (combinational)
//  ex_alu_op      out  ALU_OP_W    EX ALU operation class
//  ex_alu_src     out  1           EX operand B: 0=rs2, 1=imm
//  ex_alu_src_a   out  1           EX operand A: 0=rs1, 1=PC
//  ex_mem_read    out  1           load in EX (hazard source)
//  ex_rd          out  REG_ADDR_W  rd in EX
//  mem_branch     out  1           BEQ in MEM
//  mem_jump       out  1           JAL/JALR in MEM
//  mem_mem_read   out  1           data-memory read enable
//  mem_mem_write  out  1           data-memory write enable
//  wb_reg_write   out  1           register-file write enable
//  wb_mem_2_reg   out  1           WB select: 1=mem data, 0=ALU/link
//  wb_rd          out  REG_ADDR_W  write-back destination
// BEHAVIOUR
//  Decode (srcA,srcB,mread,mwrite,m2r,regw,branch,jump,alu_op):
//   R 0110011: 0,0,0,0,0,1,0,0,10 | I 0010011: 0,1,0,0,0,1,0,0,11 | LOAD 0000011: 0,1,1,0,1,1,0,0,00
//   STORE 0100011: 0,1,0,1,0,0,0,0,00 | BEQ 1100011: 0,0,0,0,0,0,1,0,01 | JAL 1101111: 1,1,0,0,0,1,0,1,00
//   EXT_OPS: LUI 0,1,..,regw=1,alu_op=100 (pass B); AUIPC 1,1,regw=1,00; JALR 0,1,regw=1,jump=1,00.
//   Other opcodes: id_illegal=1, bundle = bubble (all zero).
//  Bubble = all control bits 0, rd=0. Bundle regw forced 0 when id_rd==0.
//  Pipeline regs reset async to bubble; all registered outputs 0 after reset; takes effect
//   immediately on arst_n low, mid-operation included.
//  Latency: instr in ID at cycle n -> ex_* cycle n+1, mem_* n+2, wb_* n+3.
//  hazard_stall (comb) = ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | (uses_rs2 & ex_rd==id_rs2)) & !flush;
//   uses_rs2 only for R, STORE, BEQ. On stall ID/EX loads bubble; EX/MEM, MEM/WB advance.
//  flush: next edge ID/EX and EX/MEM load bubble; MEM/WB loads EX/MEM normally. Flush beats stall.
//  No enables on MEM/WB; every stage advances every cycle except as above.
//  ALU_OP_W>2: alu_op codes zero-extended. EXT_OPS=1 with ALU_OP_W<3: elaboration error.
// TESTING
//  1. Reset: arst_n=0 mid-stream -> all outputs 0 same cycle; release, first instr in ID gives ex_* next cycle.
//  2. LOAD rd=5 then ADD rs1=5 -> hazard_stall=1 one cycle, ex_* bubble, ADD re-decoded, wb_mem_2_reg=1 for load at n+3.
//  3. LOAD rd=0 then ADD rs1=0 -> hazard_stall=0; load wb_reg_write=0.
//  4. BEQ, then flush=1 while BEQ in MEM -> two younger instrs bubbled, BEQ itself reaches wb with regw=0.
//  5. flush and hazard same cycle -> hazard_stall=0, ID/EX bubble.
//  6. EXT_OPS=1, ALU_OP_W=3: LUI -> ex_alu_op=100, ex_alu_src=1; opcode 1111111 -> id_illegal=1, bubble.

Source files
------------

// File: rtl/pipelined_control_unit.sv
// Five-stage RISC-V control unit: ID decode, control bundle carried through
// ID/EX, EX/MEM and MEM/WB, with load-use stall and branch/jump flush.
module pipelined_control_unit #(
   parameter int ALU_OP_W   = 2,
   parameter int REG_ADDR_W = 5,
   parameter bit EXT_OPS    = 1'b0
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic [6:0]            id_opcode,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  flush,
   output logic                  hazard_stall,
   output logic                  id_illegal,
   output logic [ALU_OP_W-1:0]   ex_alu_op,
   output logic                  ex_alu_src,
   output logic                  ex_alu_src_a,
   output logic                  ex_mem_read,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic                  mem_branch,
   output logic                  mem_jump,
   output logic                  mem_mem_read,
   output logic                  mem_mem_write,
   output logic                  wb_reg_write,
   output logic                  wb_mem_2_reg,
   output logic [REG_ADDR_W-1:0] wb_rd
);

   if (EXT_OPS && ALU_OP_W < 3) begin : g_bad_cfg
      $error("EXT_OPS=1 needs ALU_OP_W >= 3");
   end

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;

   typedef struct packed {
      logic                  regw;
      logic                  m2r;
      logic [REG_ADDR_W-1:0] rd;
   } wb_t;

   typedef struct packed {
      logic branch;
      logic jump;
      logic mread;
      logic mwrite;
      wb_t  wb;
   } mem_t;

   typedef struct packed {
      logic                src_a;
      logic                src_b;
      logic [ALU_OP_W-1:0] alu_op;
      mem_t                m;
   } ctrl_t;

   ctrl_t dec;
   logic  illegal;
   logic  uses_rs2;
   logic  ld_use;

   ctrl_t idex_d, idex_q;
   mem_t  exmem_d, exmem_q;
   wb_t   memwb_d, memwb_q;

   always_comb begin
      dec      = '0;
      illegal  = 1'b0;
      uses_rs2 = 1'b0;
      unique case (id_opcode)
         OP_R: begin
            dec.m.wb.regw = 1'b1;
            dec.alu_op    = ALU_OP_W'(2'b10);
            uses_rs2      = 1'b1;
         end
         OP_I: begin
            dec.src_b     = 1'b1;
            dec.m.wb.regw = 1'b1;
            dec.alu_op    = ALU_OP_W'(2'b11);
         end
         OP_LOAD: begin
            dec.src_b     = 1'b1;
            dec.m.mread   = 1'b1;
            dec.m.wb.m2r  = 1'b1;
            dec.m.wb.regw = 1'b1;
         end
         OP_STORE: begin
            dec.src_b    = 1'b1;
            dec.m.mwrite = 1'b1;
            uses_rs2     = 1'b1;
         end
         OP_BEQ: begin
            dec.m.branch = 1'b1;
            dec.alu_op   = ALU_OP_W'(2'b01);
            uses_rs2     = 1'b1;
         end
         OP_JAL: begin
            dec.src_a     = 1'b1;
            dec.src_b     = 1'b1;
            dec.m.wb.regw = 1'b1;
            dec.m.jump    = 1'b1;
         end
         OP_LUI: begin
            if (EXT_OPS) begin
               dec.src_b     = 1'b1;
               dec.m.wb.regw = 1'b1;
               dec.alu_op    = ALU_OP_W'(3'b100);
            end else begin
               illegal = 1'b1;
            end
         end
         OP_AUIPC: begin
            if (EXT_OPS) begin
               dec.src_a     = 1'b1;
               dec.src_b     = 1'b1;
               dec.m.wb.regw = 1'b1;
            end else begin
               illegal = 1'b1;
            end
         end
         OP_JALR: begin
            if (EXT_OPS) begin
               dec.src_b     = 1'b1;
               dec.m.wb.regw = 1'b1;
               dec.m.jump    = 1'b1;
            end else begin
               illegal = 1'b1;
            end
         end
         default: illegal = 1'b1;
      endcase
      if (!illegal) dec.m.wb.rd = id_rd;
      // x0 is never a real destination
      if (id_rd == '0) dec.m.wb.regw = 1'b0;
   end

   assign ld_use = idex_q.m.mread
                && (idex_q.m.wb.rd != '0)
                && ((idex_q.m.wb.rd == id_rs1)
                 || (uses_rs2 && idex_q.m.wb.rd == id_rs2));

   assign hazard_stall = ld_use && !flush;
   assign id_illegal   = illegal;

   always_comb begin
      idex_d  = (flush || hazard_stall) ? '0 : dec;
      exmem_d = flush ? '0 : idex_q.m;
      memwb_d = exmem_q.wb;
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         idex_q  <= '0;
         exmem_q <= '0;
         memwb_q <= '0;
      end else begin
         idex_q  <= idex_d;
         exmem_q <= exmem_d;
         memwb_q <= memwb_d;
      end
   end

   assign ex_alu_op     = idex_q.alu_op;
   assign ex_alu_src    = idex_q.src_b;
   assign ex_alu_src_a  = idex_q.src_a;
   assign ex_mem_read   = idex_q.m.mread;
   assign ex_rd         = idex_q.m.wb.rd;
   assign mem_branch    = exmem_q.branch;
   assign mem_jump      = exmem_q.jump;
   assign mem_mem_read  = exmem_q.mread;
   assign mem_mem_write = exmem_q.mwrite;
   assign wb_reg_write  = memwb_q.regw;
   assign wb_mem_2_reg  = memwb_q.m2r;
   assign wb_rd         = memwb_q.rd;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: directed instruction stream, expected
// outputs queued per cycle and checked by an independent negedge monitor.
module tb_pipelined_control_unit;

   localparam logic [6:0] R   = 7'b0110011;
   localparam logic [6:0] I   = 7'b0010011;
   localparam logic [6:0] LD  = 7'b0000011;
   localparam logic [6:0] ST  = 7'b0100011;
   localparam logic [6:0] BQ  = 7'b1100011;
   localparam logic [6:0] JL  = 7'b1101111;
   localparam logic [6:0] LUI = 7'b0110111;
   localparam logic [6:0] AUI = 7'b0010111;
   localparam logic [6:0] JLR = 7'b1100111;
   localparam logic [6:0] BAD = 7'b1111111;

   logic       clk = 1'b0;
   logic       arst_n;
   logic [6:0] id_opcode;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic       flush;
   logic       hazard_stall, id_illegal;
   logic [2:0] ex_alu_op;
   logic       ex_alu_src, ex_alu_src_a, ex_mem_read;
   logic [4:0] ex_rd;
   logic       mem_branch, mem_jump, mem_mem_read, mem_mem_write;
   logic       wb_reg_write, wb_mem_2_reg;
   logic [4:0] wb_rd;

   pipelined_control_unit #(
      .ALU_OP_W(3), .REG_ADDR_W(5), .EXT_OPS(1'b1)
   ) dut (
      .clk(clk), .arst_n(arst_n),
      .id_opcode(id_opcode), .id_rs1(id_rs1),
      .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush),
      .hazard_stall(hazard_stall), .id_illegal(id_illegal),
      .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
      .ex_alu_src_a(ex_alu_src_a), .ex_mem_read(ex_mem_read),
      .ex_rd(ex_rd), .mem_branch(mem_branch),
      .mem_jump(mem_jump), .mem_mem_read(mem_mem_read),
      .mem_mem_write(mem_mem_write),
      .wb_reg_write(wb_reg_write), .wb_mem_2_reg(wb_mem_2_reg),
      .wb_rd(wb_rd)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      int         sel;
      logic [7:0] val;
   } chk_t;

   chk_t  sbq[$];
   int    cyc = 0;
   int    n_chk = 0;
   int    n_fail = 0;
   bit    done = 1'b0;
   bit    reported = 1'b0;
   string nm[14] = '{"hazard_stall", "id_illegal", "ex_alu_op",
      "ex_alu_src", "ex_alu_src_a", "ex_mem_read", "ex_rd",
      "mem_branch", "mem_jump", "mem_mem_read", "mem_mem_write",
      "wb_reg_write", "wb_mem_2_reg", "wb_rd"};

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] sample(input int s);
      case (s)
         0:  return {7'b0, hazard_stall};
         1:  return {7'b0, id_illegal};
         2:  return {5'b0, ex_alu_op};
         3:  return {7'b0, ex_alu_src};
         4:  return {7'b0, ex_alu_src_a};
         5:  return {7'b0, ex_mem_read};
         6:  return {3'b0, ex_rd};
         7:  return {7'b0, mem_branch};
         8:  return {7'b0, mem_jump};
         9:  return {7'b0, mem_mem_read};
         10: return {7'b0, mem_mem_write};
         11: return {7'b0, wb_reg_write};
         12: return {7'b0, wb_mem_2_reg};
         default: return {3'b0, wb_rd};
      endcase
   endfunction

   always @(negedge clk) begin
      for (int i = sbq.size() - 1; i >= 0; i--) begin
         if (sbq[i].cyc == cyc) begin
            logic [7:0] act;
            act = sample(sbq[i].sel);
            n_chk++;
            if (act !== sbq[i].val) begin
               n_fail++;
               $display("FAIL %s cyc=%0d got=%0h exp=%0h",
                  nm[sbq[i].sel], cyc, act, sbq[i].val);
            end
            sbq.delete(i);
         end
      end
      if (done && !reported) begin
         if (sbq.size() != 0) begin
            n_fail += sbq.size();
            $display("FAIL leftover %0d pending checks", sbq.size());
         end
         reported = 1'b1;
      end
   end

   task automatic push(input int c, input int s, input logic [7:0] v);
      chk_t e;
      e.cyc = c;
      e.sel = s;
      e.val = v;
      sbq.push_back(e);
   endtask

   task automatic e_id(input int c, input logic st, input logic il);
      push(c, 0, {7'b0, st});
      push(c, 1, {7'b0, il});
   endtask

   task automatic e_ex(input int c, input logic [2:0] op,
      input logic sb, input logic sa, input logic mr,
      input logic [4:0] rd);
      push(c, 2, {5'b0, op});
      push(c, 3, {7'b0, sb});
      push(c, 4, {7'b0, sa});
      push(c, 5, {7'b0, mr});
      push(c, 6, {3'b0, rd});
   endtask

   task automatic e_mem(input int c, input logic br,
      input logic jp, input logic mr, input logic mw);
      push(c, 7, {7'b0, br});
      push(c, 8, {7'b0, jp});
      push(c, 9, {7'b0, mr});
      push(c, 10, {7'b0, mw});
   endtask

   task automatic e_wb(input int c, input logic rw,
      input logic m2r, input logic [4:0] rd);
      push(c, 11, {7'b0, rw});
      push(c, 12, {7'b0, m2r});
      push(c, 13, {3'b0, rd});
   endtask

   task automatic issue(input logic [6:0] op, input logic [4:0] r1,
      input logic [4:0] r2, input logic [4:0] rd, input logic fl,
      output int n);
      @(posedge clk);
      #1;
      id_opcode = op;
      id_rs1    = r1;
      id_rs2    = r2;
      id_rd     = rd;
      flush     = fl;
      n         = cyc;
   endtask

   task automatic nop(input int k);
      int n;
      repeat (k) issue(I, 5'd0, 5'd0, 5'd0, 1'b0, n);
   endtask

   initial begin
      int n;
      int c;
      arst_n    = 1'b0;
      id_opcode = I;
      id_rs1    = '0;
      id_rs2    = '0;
      id_rd     = '0;
      flush     = 1'b0;

      @(posedge clk);
      #1;
      c = cyc;
      push(c, 0, 8'd0);
      e_ex(c, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
      e_mem(c, 1'b0, 1'b0, 1'b0, 1'b0);
      e_wb(c, 1'b0, 1'b0, 5'd0);
      @(negedge clk);
      #1;
      arst_n = 1'b1;

      issue(R, 5'd1, 5'd2, 5'd3, 1'b0, n);
      e_id(n, 1'b0, 1'b0);
      e_ex(n + 1, 3'b010, 1'b0, 1'b0, 1'b0, 5'd3);
      e_mem(n + 2, 1'b0, 1'b0, 1'b0, 1'b0);
      e_wb(n + 3, 1'b1, 1'b0, 5'd3);
      nop(3);

      issue(LD, 5'd1, 5'd0, 5'd5, 1'b0, n);
      e_ex(n + 1, 3'b000, 1'b1, 1'b0, 1'b1, 5'd5);
      e_mem(n + 2, 1'b0, 1'b0, 1'b1, 1'b0);
      e_wb(n + 3, 1'b1, 1'b1, 5'd5);
      issue(R, 5'd5, 5'd6, 5'd7, 1'b0, n);
      e_id(n, 1'b1, 1'b0);
      e_ex(n + 1, 3'b000, 1'b0, 1'b0, 1'b0, 5'd0);
      e_wb(n + 3, 1'b0, 1'b0, 5'd0);
      issue(R, 5'd5, 5'd6, 5'd7, 1'b0, n);
      e_id(n, 1'b0, 1'b0);
      e_ex(n + 1, 3'b010, 1'b0, 1'b0, 1'b0, 5'd7);
      e_wb(n + 3, 1'b1, 1'b0, 5'd7);
      nop(3);

      issue(LD, 5'd1, 5'd0, 5'd0, 1'b0, n);
      e_wb(n + 3, 1'b0, 1'b1, 5'd0);
      issue(R, 5'd0, 5'd0, 5'd8, 1'b0, n);
      e_id(n, 1'b0, 1'b0);
      e_ex(n + 1, 3'b010, 1'b0, 1'b0, 1'b0, 5'd8);
      nop(3);

      issue(LD, 5'd1, 5'd0, 5'd9, 1'b0, n);
      issue(I, 5'd1, 5'd9, 5'd10, 1'b0, n);
      e_id(n, 1'b0, 1'b0);
      e_ex(n + 1, 3'b011, 1'b1, 1'b0, 1'b0, 5'd10);
      issue(LD, 5'd1, 5'd0, 5'd11, 1'b0, n);
      issue(ST, 5'd1, 5'd11, 5'd0, 1'b0, n);
      e_id(n, 1'b1, 1'b0);
      issue(ST, 5'd1, 5'd11, 5'd0, 1'b0, n);
      e_id(n, 1'b0, 1'b0);
      e_ex(n + 1, 3'b000, 1'b1, 1'b0, 1'b0, 5'd0);
      e_mem(n + 2, 1'b0, 1'b0, 1'b0, 1'b1);
      e_wb(n + 3, 1'b0, 1'b0, 5'd0);
      nop(3);

      issue(BQ, 5'd1, 5'd2, 5'd0, 1'b0, n);
      e_ex(n + 1, 3'b001, 1'b0, 1'b0, 1'b0, 5'd0);
      e_mem(n + 2, 1'b1, 1'b0, 1'b0, 1'b0);
      e_wb(n + 3, 1'b0, 1'b0, 5'd0);
      issue(R, 5'd3, 5'd4, 5'd12, 1'b0, n);
      e_ex(n + 1, 3'b010, 1'b0, 1'b0, 1'b0, 5'd12);
      e_mem(n + 2, 1'b0, 1'b0, 1'b0, 1'b0);
      e_wb(n + 3, 1'b0, 1'b0, 5'd0);
      issue(I, 5'd3, 5'd0, 5'd13, 1'b1, n);
      e_ex(n + 1, 3'b000, 1'b0, 1'b0, 1'b0, 5'd0);
      issue(JL, 5'd0, 5'd0, 5'd1, 1'b0, n);
      e_ex(n + 1, 3'b000, 1'b1, 1'b1, 1'b0, 5'd1);
      e_mem(n + 2, 1'b0, 1'b1, 1'b0, 1'b0);
      e_wb(n + 3, 1'b1, 1'b0, 5'd1);
      nop(3);

      issue(LD, 5'd1, 5'd0, 5'd14, 1'b0, n);
      e_ex(n + 1, 3'b000, 1'b1, 1'b0, 1'b1, 5'd14);
      issue(R, 5'd14, 5'd2, 5'd15, 1'b1, n);
      e_id(n, 1'b0, 1'b0);
      e_ex(n + 1, 3'b000, 1'b0, 1'b0, 1'b0, 5'd0);
      e_mem(n + 1, 1'b0, 1'b0, 1'b0, 1'b0);
      e_wb(n + 2, 1'b0, 1'b0, 5'd0);
      nop(3);

      issue(LUI, 5'd0, 5'd0, 5'd16, 1'b0, n);
      e_id(n, 1'b0, 1'b0);
      e_ex(n + 1, 3'b100, 1'b1, 1'b0, 1'b0, 5'd16);
      e_wb(n + 3, 1'b1, 1'b0, 5'd16);
      issue(BAD, 5'd0, 5'd0, 5'd9, 1'b0, n);
      e_id(n, 1'b0, 1'b1);
      e_ex(n + 1, 3'b000, 1'b0, 1'b0, 1'b0, 5'd0);
      e_wb(n + 3, 1'b0, 1'b0, 5'd0);
      issue(AUI, 5'd0, 5'd0, 5'd17, 1'b0, n);
      e_ex(n + 1, 3'b000, 1'b1, 1'b1, 1'b0, 5'd17);
      issue(JLR, 5'd2, 5'd0, 5'd18, 1'b0, n);
      e_ex(n + 1, 3'b000, 1'b1, 1'b0, 1'b0, 5'd18);
      e_mem(n + 2, 1'b0, 1'b1, 1'b0, 1'b0);
      e_wb(n + 3, 1'b1, 1'b0, 5'd18);
      nop(3);

      issue(LD, 5'd1, 5'd0, 5'd19, 1'b0, n);
      issue(R, 5'd1, 5'd2, 5'd20, 1'b0, n);
      issue(I, 5'd1, 5'd0, 5'd21, 1'b0, n);
      #1;
      arst_n = 1'b0;
      push(n, 0, 8'd0);
      e_ex(n, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
      e_mem(n, 1'b0, 1'b0, 1'b0, 1'b0);
      e_wb(n, 1'b0, 1'b0, 5'd0);
      @(negedge clk);
      #1;
      arst_n = 1'b1;
      issue(I, 5'd1, 5'd0, 5'd22, 1'b0, n);
      e_ex(n, 3'b011, 1'b1, 1'b0, 1'b0, 5'd21);
      e_mem(n, 1'b0, 1'b0, 1'b0, 1'b0);
      e_wb(n, 1'b0, 1'b0, 5'd0);
      e_ex(n + 1, 3'b011, 1'b1, 1'b0, 1'b0, 5'd22);
      nop(5);

      done = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      if (!reported) begin
         n_fail++;
         $display("FAIL monitor_final got=0 exp=1");
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
         n_chk, n_fail);
      $finish;
   end

endmodule
